// File: rtl/tinycomp_in_port.sv
// TinyComp input port: buffers producer bytes in a small FIFO and serves CPU I/O reads.
// Optional TCIN_OVERFLOW_EN: producer never back-pressured; drops set a sticky overflow flag.
module tinycomp_in_port #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] DATA_ADDR = 32'h0000_03fe,
    parameter logic [31:0] STAT_ADDR = 32'h0000_03fd
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] IOaddr,
    input  logic        InStrobe,
    output logic [31:0] InData,
    output logic        InRdy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_flag;

    logic        empty, full, hit_d, hit_s, push, pop;
    logic [31:0] stat_word;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign hit_d = (IOaddr == DATA_ADDR);
    assign hit_s = (IOaddr == STAT_ADDR);
    assign pop   = InStrobe && hit_d && !empty;

`ifdef TCIN_OVERFLOW_EN
    logic ovf_q, ovf_d, drop;

    assign in_ready = !Reset;
    assign push     = in_valid && !full && !Reset;
    assign drop     = in_valid && full;
    assign ovf_flag = ovf_q;

    // A drop in the same cycle as a clearing status read leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (InStrobe && hit_s) ovf_d = 1'b0;
        if (drop)              ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end
`else
    assign in_ready = !Reset && !full;
    assign push     = in_valid && in_ready;
    assign ovf_flag = 1'b0;
`endif

    assign stat_word = {16'h0000, {(8-CW){1'b0}}, count_q, 5'b00000, ovf_flag, full, !empty};

    always_comb begin
        InData = '0;
        InRdy  = 1'b1;
        if (hit_d) begin
            InRdy = !empty;
            if (!empty) InData = {24'h000000, mem_q[rd_ptr_q]};
        end else if (hit_s) begin
            InData = stat_word;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_tinycomp_in_port.sv
// Bench for tinycomp_in_port: directed vector table, overflow sequence, and random traffic
// checked against a queue-based model of the port.
module tb_tinycomp_in_port;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] DA = 32'h0000_03fe;
    localparam logic [31:0] SA = 32'h0000_03fd;
    localparam logic [31:0] OA = 32'h0000_0100;
`ifdef TCIN_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] IOaddr = '0;
    logic        InStrobe = 1'b0;
    logic [31:0] InData;
    logic        InRdy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] mq[$];
    bit         movf = 1'b0;

    tinycomp_in_port #(.DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
        .clk(clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .IOaddr(IOaddr), .InStrobe(InStrobe),
        .InData(InData), .InRdy(InRdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        strobe;
        logic        valid;
        logic [7:0]  data;
        logic        rst;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_inr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] a, input logic s, input logic v,
                                input logic [7:0] d, input logic r,
                                input logic [31:0] ed, input logic er, input logic ei);
        vec_t t;
        t.addr = a; t.strobe = s; t.valid = v; t.data = d; t.rst = r;
        t.e_data = ed; t.e_rdy = er; t.e_inr = ei;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, clock, advance the model.
    task automatic step(input logic [31:0] a, input logic s, input logic v, input logic [7:0] d,
                        input logic r, output logic [31:0] o_data, output logic o_rdy,
                        output logic o_inr);
        bit emp, ful, do_pop, do_push, do_drop;
        logic [31:0] e_data;
        logic e_rdy, e_inr;
        @(negedge clk);
        IOaddr = a; InStrobe = s; in_valid = v; in_data = d; Reset = r;
        #1;
        emp = (mq.size() == 0);
        ful = (mq.size() == DEPTH);
        e_inr = r ? 1'b0 : (OVF ? 1'b1 : !ful);
        if (a == DA) begin
            e_rdy  = !emp;
            e_data = emp ? 32'h0 : {24'h0, mq[0]};
        end else if (a == SA) begin
            e_rdy  = 1'b1;
            e_data = 32'h0 | (32'(mq.size()) << 8) | (32'(movf) << 2) | (32'(ful) << 1) | 32'(!emp);
        end else begin
            e_rdy  = 1'b1;
            e_data = 32'h0;
        end
        o_data = InData; o_rdy = InRdy; o_inr = in_ready;
        chk("model_indata", InData, e_data);
        chk("model_inrdy", {31'h0, InRdy}, {31'h0, e_rdy});
        chk("model_in_ready", {31'h0, in_ready}, {31'h0, e_inr});
        @(posedge clk);
        if (r) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            do_pop  = s && (a == DA) && !emp;
            do_push = v && !ful;
            do_drop = OVF && v && ful;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (s && (a == SA)) movf = 1'b0;
            if (do_drop) movf = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] od;
        logic        ordy, oinr;

        // Directed table from an empty FIFO (default build expectations).
        tbl.push_back(mk(SA, 0, 0, 8'h00, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(DA, 0, 0, 8'h00, 0, 32'h0000_0000, 0, 1));
        tbl.push_back(mk(OA, 1, 0, 8'h00, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'hA5, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h3C, 0, 32'h0000_0101, 1, 1));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_00A5, 1, 1));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_003C, 1, 1));
        tbl.push_back(mk(SA, 0, 0, 8'h00, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h01, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h02, 0, 32'h0000_0101, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h03, 0, 32'h0000_0201, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h04, 0, 32'h0000_0301, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h05, 0, 32'h0000_0403, 1, 0));
        tbl.push_back(mk(DA, 1, 1, 8'h05, 0, 32'h0000_0001, 1, 0));
        tbl.push_back(mk(DA, 0, 1, 8'h05, 0, 32'h0000_0002, 1, 1));
        tbl.push_back(mk(SA, 0, 0, 8'h00, 0, 32'h0000_0403, 1, 0));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_0002, 1, 0));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_0003, 1, 1));
        tbl.push_back(mk(DA, 1, 1, 8'h77, 0, 32'h0000_0004, 1, 1));
        tbl.push_back(mk(SA, 0, 0, 8'h00, 0, 32'h0000_0201, 1, 1));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_0005, 1, 1));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_0077, 1, 1));
        tbl.push_back(mk(DA, 0, 0, 8'h00, 0, 32'h0000_0000, 0, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h11, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h22, 0, 32'h0000_0101, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h33, 0, 32'h0000_0201, 1, 1));
        tbl.push_back(mk(SA, 0, 1, 8'h44, 1, 32'h0000_0301, 1, 0));
        tbl.push_back(mk(SA, 0, 0, 8'h00, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(DA, 1, 0, 8'h00, 0, 32'h0000_0000, 0, 1));

        step(SA, 0, 0, 8'h00, 1, od, ordy, oinr);
        step(SA, 0, 0, 8'h00, 1, od, ordy, oinr);

        foreach (tbl[i]) begin
            step(tbl[i].addr, tbl[i].strobe, tbl[i].valid, tbl[i].data, tbl[i].rst, od, ordy, oinr);
            if (!OVF) begin
                chk($sformatf("tbl%0d_indata", i), od, tbl[i].e_data);
                chk($sformatf("tbl%0d_inrdy", i), {31'h0, ordy}, {31'h0, tbl[i].e_rdy});
                chk($sformatf("tbl%0d_in_ready", i), {31'h0, oinr}, {31'h0, tbl[i].e_inr});
            end
        end

        // Push/pop pairs around the ring with two entries resident.
        step(SA, 0, 1, 8'h90, 0, od, ordy, oinr);
        step(SA, 0, 1, 8'h91, 0, od, ordy, oinr);
        for (int k = 0; k < 10; k++) begin
            step(DA, 1, 1, 8'(8'hA0 + k), 0, od, ordy, oinr);
            chk("wrap_order", od, (k < 2) ? {24'h0, 8'(8'h90 + k)} : {24'h0, 8'(8'hA0 + k - 2)});
        end
        step(SA, 0, 0, 8'h00, 0, od, ordy, oinr);
        chk("wrap_status", od, 32'h0000_0201);
        step(SA, 0, 0, 8'h00, 1, od, ordy, oinr);

`ifdef TCIN_OVERFLOW_EN
        for (int k = 1; k <= 4; k++) step(SA, 0, 1, 8'(k), 0, od, ordy, oinr);
        step(SA, 0, 1, 8'hEE, 0, od, ordy, oinr);
        chk("ovf_ready_full", {31'h0, oinr}, 32'h1);
        step(SA, 1, 0, 8'h00, 0, od, ordy, oinr);
        chk("ovf_status_set", od, 32'h0000_0407);
        step(SA, 0, 0, 8'h00, 0, od, ordy, oinr);
        chk("ovf_status_clr", od, 32'h0000_0403);
        for (int k = 1; k <= 4; k++) begin
            step(DA, 1, 0, 8'h00, 0, od, ordy, oinr);
            chk("ovf_data", od, 32'(k));
        end
        step(SA, 0, 0, 8'h00, 1, od, ordy, oinr);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0, 1:    a = DA;
                2:       a = SA;
                default: a = $urandom;
            endcase
            step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 8'($urandom),
                 1'($urandom_range(0, 63) == 0), od, ordy, oinr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
